// File: rtl/dwrr_scheduler.sv
// Deficit-weighted round-robin scheduler for the multichannel buffer egress.
// Each visit to a requesting flow tops up its deficit by its quantum. Whole
// packets are then granted one at a time for as long as the deficit covers
// the head packet length. Only one packet is in flight at any time.
module dwrr_scheduler #(
    parameter int FLOW_W          = 3,
    parameter int LEN_W           = 8,
    parameter int QUANTUM_W       = 8,
    parameter int DEFICIT_W       = 10,
    parameter int DEFAULT_QUANTUM = 16,
    localparam int NUM_FLOWS      = 2 ** FLOW_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_FLOWS-1:0]       flow_req,
    input  logic [NUM_FLOWS*LEN_W-1:0] head_len,
    input  logic                       quantum_wr_en,
    input  logic [FLOW_W-1:0]          quantum_wr_flow,
    input  logic [QUANTUM_W-1:0]       quantum_wr_data,
    output logic                       grant_valid,
    output logic [FLOW_W-1:0]          grant_flow,
    input  logic                       grant_ready,
    input  logic                       pkt_done,
    output logic                       init_done,
    output logic                       busy
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SCAN,
        ST_CHECK,
        ST_GRANT,
        ST_WAIT_DONE
    } state_t;

    state_t               state;
    logic [QUANTUM_W-1:0] quantum [NUM_FLOWS];
    logic [DEFICIT_W-1:0] deficit [NUM_FLOWS];
    logic [FLOW_W-1:0]    rr_ptr;
    logic [FLOW_W-1:0]    cur;
    logic [FLOW_W-1:0]    init_cnt;
    logic [LEN_W-1:0]     len_q;

    logic                 scan_hit;
    logic [FLOW_W-1:0]    scan_flow;
    logic [DEFICIT_W:0]   scan_sum;
    logic [DEFICIT_W-1:0] scan_sum_sat;
    logic [LEN_W-1:0]     cur_len_raw;
    logic [LEN_W-1:0]     cur_len;
    logic                 len_fits;

    // Find the first requesting flow at or after rr_ptr, wrapping around.
    // Walking the offsets from highest to lowest lets the nearest one win.
    always_comb begin
        logic [FLOW_W-1:0] idx;
        scan_hit  = 1'b0;
        scan_flow = rr_ptr;
        idx       = rr_ptr;
        for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
            idx = rr_ptr + FLOW_W'(i);
            if (flow_req[idx]) begin
                scan_hit  = 1'b1;
                scan_flow = idx;
            end
        end
    end

    // Saturating deficit top-up for the flow the scan has picked.
    always_comb begin
        scan_sum     = {1'b0, deficit[scan_flow]} + (DEFICIT_W + 1)'(quantum[scan_flow]);
        scan_sum_sat = scan_sum[DEFICIT_W] ? {DEFICIT_W{1'b1}} : scan_sum[DEFICIT_W-1:0];
    end

    // Head length of the current flow. A zero length still costs one word.
    always_comb begin
        cur_len_raw = head_len[int'(cur) * LEN_W +: LEN_W];
        cur_len     = (cur_len_raw == '0) ? LEN_W'(1) : cur_len_raw;
        len_fits    = (DEFICIT_W'(cur_len) <= deficit[cur]);
    end

    // Main scheduler FSM: init sweep, scan, deficit check, grant handshake, packet completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            grant_valid <= 1'b0;
            grant_flow  <= '0;
            init_done   <= 1'b0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            init_cnt    <= '0;
            cur         <= '0;
            len_q       <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    quantum[init_cnt] <= QUANTUM_W'(DEFAULT_QUANTUM);
                    deficit[init_cnt] <= '0;
                    init_cnt          <= init_cnt + 1'b1;
                    if (init_cnt == FLOW_W'(NUM_FLOWS - 1)) begin
                        init_done <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_hit) begin
                        cur                <= scan_flow;
                        deficit[scan_flow] <= scan_sum_sat;
                        state              <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!flow_req[cur]) begin
                        deficit[cur] <= '0;
                        rr_ptr       <= cur + 1'b1;
                        state        <= ST_SCAN;
                    end else if (len_fits) begin
                        len_q       <= cur_len;
                        grant_valid <= 1'b1;
                        grant_flow  <= cur;
                        busy        <= 1'b1;
                        state       <= ST_GRANT;
                    end else begin
                        rr_ptr <= cur + 1'b1;
                        state  <= ST_SCAN;
                    end
                end
                ST_GRANT: begin
                    if (grant_ready) begin
                        grant_valid  <= 1'b0;
                        deficit[cur] <= deficit[cur] - DEFICIT_W'(len_q);
                        state        <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (pkt_done) begin
                        busy  <= 1'b0;
                        state <= ST_CHECK;
                    end
                end
                default: state <= ST_INIT;
            endcase

            if (init_done && quantum_wr_en) begin
                quantum[quantum_wr_flow] <= quantum_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_dwrr_scheduler.sv
// Scoreboard bench for dwrr_scheduler. Expected grant flows are queued by the
// stimulus process and popped by a monitor on every grant handshake.
module tb_dwrr_scheduler;

    localparam int FLOW_W    = 3;
    localparam int LEN_W     = 8;
    localparam int QUANTUM_W = 8;
    localparam int NUM_FLOWS = 2 ** FLOW_W;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_FLOWS-1:0]       flow_req = '0;
    logic [NUM_FLOWS*LEN_W-1:0] head_len = '0;
    logic                       quantum_wr_en = 1'b0;
    logic [FLOW_W-1:0]          quantum_wr_flow = '0;
    logic [QUANTUM_W-1:0]       quantum_wr_data = '0;
    logic                       grant_valid;
    logic [FLOW_W-1:0]          grant_flow;
    logic                       grant_ready = 1'b1;
    logic                       pkt_done = 1'b0;
    logic                       init_done;
    logic                       busy;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    dwrr_scheduler #(
        .FLOW_W(FLOW_W),
        .LEN_W(LEN_W),
        .QUANTUM_W(QUANTUM_W),
        .DEFICIT_W(10),
        .DEFAULT_QUANTUM(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flow_req(flow_req),
        .head_len(head_len),
        .quantum_wr_en(quantum_wr_en),
        .quantum_wr_flow(quantum_wr_flow),
        .quantum_wr_data(quantum_wr_data),
        .grant_valid(grant_valid),
        .grant_flow(grant_flow),
        .grant_ready(grant_ready),
        .pkt_done(pkt_done),
        .init_done(init_done),
        .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_FLOWS-1:0] req, input logic [NUM_FLOWS*LEN_W-1:0] lens);
        flow_req = req;
        head_len = lens;
    endtask

    function automatic logic [NUM_FLOWS*LEN_W-1:0] lenVec(input int f, input int l,
                                                          input logic [NUM_FLOWS*LEN_W-1:0] base);
        logic [NUM_FLOWS*LEN_W-1:0] v;
        v = base;
        v[f*LEN_W +: LEN_W] = LEN_W'(l);
        return v;
    endfunction

    task automatic pushExpected(input int f, input int count);
        for (int i = 0; i < count; i++) exp_q.push_back(f);
    endtask

    // Pulse rst, then check the init sweep timing. A quantum write issued
    // mid-sweep (to an already swept flow) must be ignored.
    task automatic applyReset();
        tick();
        rst = 1'b1;
        quantum_wr_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            @(negedge clk);
            checkOutput("init_done_low", int'(init_done), 0);
            checkOutput("grant_valid_low", int'(grant_valid), 0);
            checkOutput("busy_low", int'(busy), 0);
            if (i == 5) begin
                quantum_wr_en   = 1'b1;
                quantum_wr_flow = 3'd3;
                quantum_wr_data = 8'd0;
            end else begin
                quantum_wr_en = 1'b0;
            end
        end
        @(negedge clk);
        quantum_wr_en = 1'b0;
        checkOutput("init_done_high", int'(init_done), 1);
    endtask

    task automatic writeQuantum(input int f, input int q);
        tick();
        quantum_wr_en   = 1'b1;
        quantum_wr_flow = FLOW_W'(f);
        quantum_wr_data = QUANTUM_W'(q);
        tick();
        quantum_wr_en = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        checkOutput(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Drop all requests right after the last expected handshake, then give
    // the monitor time to catch any stray grant.
    task automatic endScenario();
        applyStimulus('0, head_len);
        repeat (15) tick();
    endtask

    // Monitor: every handshake pops one expected flow.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && grant_valid === 1'b1 && grant_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_grant_flow", int'(grant_flow), -1);
                end else begin
                    checkOutput("grant_flow", int'(grant_flow), exp_q.pop_front());
                    checkOutput("busy_at_grant", int'(busy), 1);
                end
            end
        end
    end

    // Datapath model: tlast leaves three cycles after the handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && grant_valid === 1'b1 && grant_ready) begin
                repeat (3) @(posedge clk);
                #1 pkt_done = 1'b1;
                @(posedge clk);
                #1 pkt_done = 1'b0;
            end
        end
    end

    // Safety net so the run always terminates.
    initial begin
        #500000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        bit found;
        applyReset();

        // Flow 2 alone, len 4: repeated grants, and regrant two cycles after tlast.
        pushExpected(2, 6);
        applyStimulus(8'b0000_0100, lenVec(2, 4, '0));
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (pkt_done) found = 1'b1;
        end
        checkOutput("pkt_done_seen", int'(found), 1);
        @(negedge clk);
        checkOutput("gap_check_cycle_idle", int'(grant_valid), 0);
        @(negedge clk);
        checkOutput("gap_regrant_valid", int'(grant_valid), 1);
        checkOutput("gap_regrant_flow", int'(grant_flow), 2);
        waitDrain("drain_single", 400);
        endScenario();
        applyReset();

        // Flows 2 and 4, len 10: residual deficits decide the interleave.
        exp_q = '{2, 4, 2, 2, 4, 4, 2, 4, 2, 2};
        applyStimulus(8'b0001_0100, lenVec(4, 10, lenVec(2, 10, '0)));
        waitDrain("drain_len10", 800);
        endScenario();
        applyReset();

        // Flows 0 and 5, len 4: four packets per visit.
        pushExpected(0, 4);
        pushExpected(5, 4);
        pushExpected(0, 4);
        applyStimulus(8'b0010_0001, lenVec(5, 4, lenVec(0, 4, '0)));
        waitDrain("drain_two_flows", 1000);
        endScenario();
        applyReset();

        // Flow 1 len 40 needs three visits; flow 6 len 16 interleaves.
        exp_q = '{6, 6, 1, 6, 6, 1, 6, 6, 6, 1};
        applyStimulus(8'b0100_0010, lenVec(6, 16, lenVec(1, 40, '0)));
        waitDrain("drain_long_pkt", 1000);
        endScenario();
        applyReset();

        // Quantum 32 on flow 6; flow 3 keeps 16 despite the write during init.
        writeQuantum(6, 32);
        exp_q = '{3, 6, 6, 3, 6, 6, 3, 6, 6};
        applyStimulus(8'b0100_1000, lenVec(6, 16, lenVec(3, 16, '0)));
        waitDrain("drain_quantum_wr", 1000);
        endScenario();
        applyReset();

        // Flow 3 drops after one packet; its deficit must be cleared.
        exp_q = '{3};
        applyStimulus(8'b0010_1000, lenVec(5, 4, lenVec(3, 4, '0)));
        waitDrain("drain_drop_a", 200);
        pushExpected(5, 4);
        applyStimulus(8'b0010_0000, head_len);
        waitDrain("drain_drop_b", 400);
        pushExpected(3, 4);
        pushExpected(5, 1);
        applyStimulus(8'b0010_1000, head_len);
        waitDrain("drain_drop_c", 500);
        endScenario();
        applyReset();

        // Zero length costs one word: flow 7 gets sixteen packets per visit.
        pushExpected(0, 1);
        pushExpected(7, 16);
        pushExpected(0, 1);
        applyStimulus(8'b1000_0001, lenVec(7, 0, lenVec(0, 16, '0)));
        waitDrain("drain_zero_len", 1500);
        endScenario();
        applyReset();

        // Grant held while grant_ready is low, then aborted by reset.
        grant_ready = 1'b0;
        applyStimulus(8'b0001_0000, lenVec(4, 4, '0));
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (grant_valid === 1'b1) found = 1'b1;
        end
        checkOutput("held_grant_seen", int'(found), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("held_grant_valid", int'(grant_valid), 1);
            checkOutput("held_grant_flow", int'(grant_flow), 4);
            checkOutput("held_busy", int'(busy), 1);
        end
        applyStimulus('0, '0);
        applyReset();
        grant_ready = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dwrr_scheduler.md
Name: dwrr_scheduler

Overview:
Deficit-weighted round-robin scheduler for the multichannel buffer egress. Holds a per-flow quantum and a per-flow deficit counter, and visits non-empty flows in round-robin order. Each visit adds that flow's quantum to its deficit; the scheduler then grants whole packets while the deficit covers the head packet length. It sits between the per-flow queue status and the egress read datapath, and gates each packet on the datapath's grant handshake and end-of-packet (tlast) indication.

Parameters:
FLOW_W, 3, flow index width; NUM_FLOWS = 2**FLOW_W
LEN_W, 8, head packet length width, in words
QUANTUM_W, 8, per-flow quantum width
DEFICIT_W, 10, deficit counter width; must be > max(LEN_W, QUANTUM_W)
DEFAULT_QUANTUM, 16, quantum loaded into every flow during init

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flow_req  in  NUM_FLOWS  bit i = flow i has a packet at its queue head
head_len  in  NUM_FLOWS*LEN_W  head packet length per flow (slice i); stable while flow_req[i]=1
quantum_wr_en  in  1  write a quantum
quantum_wr_flow  in  FLOW_W  target flow of the quantum write
quantum_wr_data  in  QUANTUM_W  new quantum value
grant_valid  out  1  a grant is offered
grant_flow  out  FLOW_W  flow being granted
grant_ready  in  1  datapath accepts the grant
pkt_done  in  1  tlast of the granted packet has left the datapath
init_done  out  1  init sequence complete
busy  out  1  FSM is in GRANT or WAIT_DONE

Behaviour:
- Reset, applied when rst=1 at a clk edge:
  - State goes to INIT; grant_valid=0, grant_flow=0, init_done=0, busy=0.
  - rr_ptr=0, init counter=0.
  - Reset mid-operation aborts any grant in progress. grant_valid is low from the cycle after rst is sampled.
- INIT:
  - One flow per cycle: quantum[k]<=DEFAULT_QUANTUM, deficit[k]<=0.
  - After NUM_FLOWS cycles, init_done<=1 and the FSM goes to SCAN.
  - Quantum writes during INIT are ignored.
- SCAN (1 cycle):
  - Rotate flow_req by rr_ptr and priority-encode to find the first requesting flow f at or after rr_ptr, wrapping modulo NUM_FLOWS.
  - If no flow requests, stay in SCAN with rr_ptr unchanged.
  - Otherwise: cur<=f; deficit[f]<=sat(deficit[f]+quantum[f]); go to CHECK.
- CHECK (1 cycle). Let L = head_len[cur], with L=0 treated as 1.
  - If flow_req[cur]=0: deficit[cur]<=0, rr_ptr<=cur+1 (wraps), go to SCAN.
  - Else if L <= deficit[cur]: latch L into len_q, set grant_valid<=1 and grant_flow<=cur, go to GRANT.
  - Else: deficit is retained, rr_ptr<=cur+1, go to SCAN.
- GRANT:
  - grant_valid and grant_flow are held stable until grant_ready=1.
  - On the handshake cycle: grant_valid<=0, deficit[cur]<=deficit[cur]-len_q (never underflows), go to WAIT_DONE.
- WAIT_DONE:
  - Wait for pkt_done=1, then go to CHECK on the same flow; no additional quantum is added.
  - pkt_done outside WAIT_DONE is ignored.
- Arithmetic:
  - The add saturates at 2**DEFICIT_W-1.
  - The quantum is zero-extended to DEFICIT_W.
  - A quantum of 0 gives the flow no service unless it carries a residual deficit.
- Quantum writes, when init_done=1:
  - Take effect on the next clk.
  - Are applied at the flow's next SCAN add; an add already done for the current visit is unaffected.
- Simultaneous events:
  - A quantum write to cur in the same cycle as the SCAN add: the add uses the old quantum.
  - rst has priority over everything.
- Throughput: at most one packet in flight. Minimum gap between grants on the same flow is 2 cycles after pkt_done (CHECK, then GRANT).

Test Plan:
- Init: deassert rst, hold flow_req=0 -> init_done rises after 8 cycles; grant_valid stays 0; all deficits 0.
- Single flow 2, head_len=10, quantum 16, grant_ready=1, pkt_done 3 cycles after the grant -> grant_flow=2, deficit 16->6. CHECK then fails (10>6) -> rr_ptr=3; on the next visit deficit 6+16=22 -> grant.
- Flows 0 and 5 both requesting, len 4, quantum 16 -> flow 0 gets 4 packets (deficit 16,12,8,4,0), then flow 5 gets 4; order repeats.
- Flow 1 with len 40, quantum 16 -> no grant on visits 1 and 2 (deficit 16, 32); grant on the 3rd visit (48), leaving deficit 8.
- Flow 3 drops flow_req after one packet -> deficit[3] cleared to 0 at CHECK; rr_ptr=4.
- grant_ready held 0 for 5 cycles, then rst=1 -> grant_valid stays stable for 5 cycles, falls the cycle after rst; INIT re-runs; init_done=0 for 8 cycles.
